// File: rtl/tm_arb_pkg.sv
// rtl/tm_arb_pkg.sv - shared types and helpers for the tape memory arbiter
package tm_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_LOADER  = 2'd0,
    REQ_COMPUTE = 2'd1,
    REQ_DEBUG   = 2'd2,
    REQ_NONE    = 2'd3
  } req_idx_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Requester index to one-hot; REQ_NONE maps to all zeros.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // Lowest set index wins; 3 when nothing is set.
  function automatic logic [1:0] pick_lowest(input logic [NUM_REQ-1:0] v);
    logic [1:0] idx;
    idx = REQ_NONE;
    if (v[0])      idx = REQ_LOADER;
    else if (v[1]) idx = REQ_COMPUTE;
    else if (v[2]) idx = REQ_DEBUG;
    return idx;
  endfunction

endpackage

// File: rtl/arb_age_counter.sv
// rtl/arb_age_counter.sv - saturating wait counter flagging a starved requester
module arb_age_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic aged_o
);

  logic [3:0] cnt_q, cnt_d;

  assign aged_o = (cnt_q == 4'(MAX_WAIT));

  // Clear wins over increment; the count parks at MAX_WAIT until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (inc_i && !aged_o) cnt_d = cnt_q + 4'd1;
  end

  // Count register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tape_mem_arbiter.sv
// rtl/tape_mem_arbiter.sv - registered priority/aging arbiter for the single-port tape memory
module tape_mem_arbiter
  import tm_arb_pkg::*;
#(
  parameter int DW       = 4,
  parameter int W        = 64,
  parameter int AW       = $clog2(W),
  parameter int MAX_WAIT = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  input  logic [NUM_REQ*DW-1:0] wdata_i,
  input  logic [NUM_REQ-1:0]    lock_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic [1:0]            owner_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DW-1:0]         mem_wdata_o,
  input  logic [DW-1:0]         mem_rdata_i
);

  arb_state_e           state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic                 re_q, re_d, we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [NUM_REQ-1:0]   win_oh, elig, aged, owner_oh;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
    arb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .inc_i   (req_i[g] & ~win_oh[g]),
      .clr_i   (~req_i[g] | win_oh[g]),
      .aged_o  (aged[g])
    );
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = (|rvalid_q) ? mem_rdata_i : '0;
  assign owner_o     = owner_q;
  assign mem_re_o    = re_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Pick this edge's winner and the next FSM state. A locked owner with req
  // high always gets the slot (its lock at that edge decides whether the lock
  // continues); a locked owner that withdraws while still locking idles the
  // memory; otherwise aged requesters beat fixed order, and last cycle's
  // grantee sits out one decision.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = '0;
    re_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    win_oh   = '0;
    owner_oh = idx_to_onehot(owner_q);
    elig     = req_i & ~gnt_q;
    rvalid_d = gnt_q & {NUM_REQ{re_q}};

    if (state_q == LOCKED && |(req_i & owner_oh)) begin
      win_oh = owner_oh;
    end else if (state_q == LOCKED && |(lock_i & owner_oh)) begin
      win_oh = '0;
    end else if (|(elig & aged)) begin
      win_oh = idx_to_onehot(pick_lowest(elig & aged));
    end else begin
      win_oh = idx_to_onehot(pick_lowest(elig));
    end

    if (|win_oh) begin
      state_d = (|(lock_i & win_oh)) ? LOCKED : GRANT;
    end else if (!(state_q == LOCKED && |(lock_i & owner_oh))) begin
      state_d = IDLE;
    end

    gnt_d = win_oh;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        we_d    = we_i[i];
        re_d    = ~we_i[i];
        addr_d  = addr_i[i*AW +: AW];
        wdata_d = wdata_i[i*DW +: DW];
        owner_d = 2'(i);
      end
    end
  end

  // Registered decision and memory command; reset drops any pending read.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      owner_q  <= REQ_NONE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      re_q     <= re_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// tb/tb_tape_mem_arbiter.sv - scoreboard bench for the tape memory arbiter
module tb_tape_mem_arbiter;

  typedef struct packed {
    logic [1:0] idx;
    logic       we;
    logic [5:0] addr;
    logic [3:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0, we = '0, lock = '0;
  logic [17:0] addr = '0;
  logic [11:0] wdata = '0;
  logic [2:0]  gnt, rvalid;
  logic [3:0]  rdata;
  logic [1:0]  owner;
  logic        mem_re, mem_we;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata = '0;

  logic [3:0]  mem [64];
  logic        mem_loaded = 1'b0;
  logic [3:0]  exp_mem [64];
  logic [2:0]  auto_drop = 3'b111;

  gnt_exp_t    gq[$];
  rd_exp_t     rq[$];
  gnt_exp_t    ge;
  rd_exp_t     re;
  int          checks = 0;
  int          errors = 0;

  tape_mem_arbiter #(.DW(4), .W(64), .AW(6), .MAX_WAIT(8)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .lock_i      (lock),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .owner_o     (owner),
    .mem_re_o    (mem_re),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 4'(i) ^ 4'hF;
      mem_loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  // Monitor: every presented grant / read return is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 3'b000) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL gnt_unexpected: got gnt=%b addr=%0d, expected no grant", gnt, mem_addr);
        end else begin
          ge = gq.pop_front();
          if (gnt !== (3'b001 << ge.idx) || mem_we !== ge.we || mem_re !== ~ge.we ||
              mem_addr !== ge.addr || (ge.we && mem_wdata !== ge.wdata) || owner !== ge.idx) begin
            errors++;
            $display("FAIL gnt_match: got gnt=%b re=%b we=%b addr=%0d wdata=%h owner=%0d, expected req=%0d we=%b addr=%0d wdata=%h",
                     gnt, mem_re, mem_we, mem_addr, mem_wdata, owner, ge.idx, ge.we, ge.addr, ge.wdata);
          end
        end
      end
      if (rvalid != 3'b000) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h, expected none", rvalid, rdata);
        end else begin
          re = rq.pop_front();
          if (rvalid !== (3'b001 << re.idx) || rdata !== re.data) begin
            errors++;
            $display("FAIL rvalid_match: got rvalid=%b rdata=%h, expected req=%0d rdata=%h",
                     rvalid, rdata, re.idx, re.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; requesters drop req once they see gnt.
  task automatic tick();
    @(negedge clk);
    req = req & ~(gnt & auto_drop);
  endtask

  task automatic set_req(input int i, input logic w, input logic [5:0] a,
                         input logic [3:0] d, input logic l);
    req[i]            = 1'b1;
    we[i]             = w;
    addr[i*6 +: 6]    = a;
    wdata[i*4 +: 4]   = d;
    lock[i]           = l;
  endtask

  task automatic expect_access(input int i, input logic w, input logic [5:0] a, input logic [3:0] d);
    gnt_exp_t g;
    rd_exp_t  r;
    g.idx = 2'(i); g.we = w; g.addr = a; g.wdata = d;
    gq.push_back(g);
    if (w) begin
      exp_mem[a] = d;
    end else begin
      r.idx = 2'(i); r.data = exp_mem[a];
      rq.push_back(r);
    end
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (gq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d grants and %0d reads pending, expected 0", name, gq.size(), rq.size());
      gq.delete();
      rq.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) exp_mem[i] = 4'(i) ^ 4'hF;

    // Reset state
    tick(); tick();
    check("rst_gnt", gnt, 3'b000);
    check("rst_rvalid", rvalid, 3'b000);
    check("rst_mem_re_we", {mem_re, mem_we}, 2'b00);
    check("rst_mem_addr", mem_addr, 6'd0);
    check("rst_mem_wdata", mem_wdata, 4'd0);
    check("rst_owner", owner, 2'd3);
    rst = 1'b0;
    tick();

    // Single read: requester 1, address 5 holds A
    set_req(1, 1'b0, 6'd5, 4'h0, 1'b0);
    expect_access(1, 1'b0, 6'd5, 4'h0);
    tick();
    check("t1_gnt", gnt, 3'b010);
    check("t1_mem_re", mem_re, 1'b1);
    tick();
    check("t1_rvalid", rvalid, 3'b010);
    check("t1_rdata", rdata, 4'hA);
    drain("t1", 10);
    check("t1_owner_held", owner, 2'd1);

    // Contention: all three read together
    set_req(0, 1'b0, 6'd1, 4'h0, 1'b0);
    set_req(1, 1'b0, 6'd2, 4'h0, 1'b0);
    set_req(2, 1'b0, 6'd3, 4'h0, 1'b0);
    expect_access(0, 1'b0, 6'd1, 4'h0);
    expect_access(1, 1'b0, 6'd2, 4'h0);
    expect_access(2, 1'b0, 6'd3, 4'h0);
    tick(); check("t2_gnt0", gnt, 3'b001);
    tick(); check("t2_gnt1", {gnt, rvalid}, {3'b010, 3'b001});
    tick(); check("t2_gnt2", {gnt, rvalid}, {3'b100, 3'b010});
    tick(); check("t2_rv2", {gnt, rvalid}, {3'b000, 3'b100});
    drain("t2", 10);

    // Lock RMW on address 9 while requester 0 waits
    auto_drop = 3'b101;
    set_req(1, 1'b0, 6'd9, 4'h0, 1'b1);
    expect_access(1, 1'b0, 6'd9, 4'h0);
    tick();
    check("t3_lock_read", gnt, 3'b010);
    set_req(0, 1'b0, 6'd2, 4'h0, 1'b0);
    set_req(1, 1'b1, 6'd9, 4'h3, 1'b0);
    expect_access(1, 1'b1, 6'd9, 4'h3);
    expect_access(0, 1'b0, 6'd2, 4'h0);
    tick();
    check("t3_lock_write", {gnt, mem_we}, {3'b010, 1'b1});
    req[1] = 1'b0;
    auto_drop = 3'b111;
    tick();
    check("t3_gnt0_after", gnt, 3'b001);
    drain("t3", 10);

    // Write then read of the same address on back-to-back cycles
    set_req(0, 1'b1, 6'd12, 4'h7, 1'b0);
    set_req(1, 1'b0, 6'd12, 4'h0, 1'b0);
    expect_access(0, 1'b1, 6'd12, 4'h7);
    expect_access(1, 1'b0, 6'd12, 4'h0);
    set_req(2, 1'b0, 6'd9, 4'h0, 1'b0);
    expect_access(2, 1'b0, 6'd9, 4'h0);
    drain("t4", 12);

    // Withdraw: requester 2 pulses for one cycle while 0 is granted
    set_req(0, 1'b0, 6'd4, 4'h0, 1'b0);
    set_req(2, 1'b0, 6'd6, 4'h0, 1'b0);
    expect_access(0, 1'b0, 6'd4, 4'h0);
    tick();
    check("t5_gnt0", gnt, 3'b001);
    req[2] = 1'b0;
    drain("t5", 10);

    // Aging: 0 and 1 keep requesting, 2 must win on the 9th decision
    auto_drop = 3'b100;
    set_req(0, 1'b0, 6'd0, 4'h0, 1'b0);
    set_req(1, 1'b0, 6'd1, 4'h0, 1'b0);
    set_req(2, 1'b0, 6'd2, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      expect_access(0, 1'b0, 6'd0, 4'h0);
      expect_access(1, 1'b0, 6'd1, 4'h0);
    end
    expect_access(2, 1'b0, 6'd2, 4'h0);
    for (int k = 0; k < 8; k++) tick();
    check("t6_gnt_before_aged", gnt, 3'b010);
    tick();
    check("t6_aged_gnt2", gnt, 3'b100);
    req = '0;
    auto_drop = 3'b111;
    drain("t6", 10);

    // Reset in the cycle after a read grant
    set_req(1, 1'b0, 6'd5, 4'h0, 1'b0);
    expect_access(1, 1'b0, 6'd5, 4'h0);
    tick();
    check("t7_gnt1", gnt, 3'b010);
    #2 rst = 1'b1;
    req = '0;
    #1;
    check("t7_rvalid", rvalid, 3'b000);
    check("t7_owner", owner, 2'd3);
    check("t7_mem", {mem_re, mem_we, mem_addr, mem_wdata}, 12'd0);
    check("t7_gnt", gnt, 3'b000);
    rq.delete();
    tick(); tick();
    check("t7_rvalid_held", rvalid, 3'b000);
    rst = 1'b0;
    tick();
    set_req(2, 1'b0, 6'd7, 4'h0, 1'b0);
    expect_access(2, 1'b0, 6'd7, 4'h0);
    tick();
    check("t7_gnt_after_reset", gnt, 3'b100);
    drain("t7", 10);
    check("t7_owner_final", owner, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
